// File: rtl/fpro_dbg_pkg.sv
// Shared types and byte codes for the FPro debug bus master.
// The master turns UART command frames into single FPro bus accesses.
package fpro_dbg_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    WDATA = 3'd2,
    BUS   = 3'd3,
    RESP  = 3'd4
  } state_e;

  localparam logic [7:0] OP_WR   = 8'h57;
  localparam logic [7:0] OP_RD   = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h3F;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/fpro_dbg_master.sv
// UART-framed debug master: decodes 'W'/'R' frames into one FPro bus access
// and streams the response back. Protocol errors and inter-byte timeouts are counted.
module fpro_dbg_master
  import fpro_dbg_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        mmio_cs,
  output logic        mmio_wr,
  output logic        mmio_rd,
  output logic [20:0] mmio_addr,
  output logic [31:0] mmio_wr_data,
  input  logic [31:0] mmio_rd_data,
  output logic        busy,
  output logic [7:0]  err_cnt
);

  localparam int IW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IW-1:0] TO_VAL = IW'(TIMEOUT_CYC);

  state_e        state_r, state_n;
  logic [1:0]    byte_cnt_r, byte_cnt_n;
  logic [IW-1:0] idle_cnt_r, idle_cnt_n;
  logic          rx_fire_s, tx_fire_s, timeout_s, bad_op_s;
  logic          op_wr_r;
  logic [20:0]   addr_r;
  logic [31:0]   wdata_r;
  logic [31:0]   resp_sr_r;
  logic [2:0]    resp_left_r;
  logic [7:0]    err_cnt_r;
  logic          rx_ready_r, tx_valid_r, busy_r, cs_r, wr_r, rd_r;

  assign rx_fire_s = rx_valid && rx_ready_r;
  assign tx_fire_s = tx_valid_r && tx_ready;

  // Next-state, byte position and inter-byte idle counter
  always_comb begin
    state_n    = state_r;
    byte_cnt_n = byte_cnt_r;
    idle_cnt_n = '0;
    timeout_s  = 1'b0;
    bad_op_s   = 1'b0;
    case (state_r)
      IDLE: begin
        byte_cnt_n = 2'd0;
        if (rx_fire_s) begin
          if (rx_data == OP_WR || rx_data == OP_RD) begin
            state_n = ADDR;
          end else begin
            state_n  = RESP;
            bad_op_s = 1'b1;
          end
        end else begin
          state_n = IDLE;
        end
      end
      ADDR, WDATA: begin
        // The timeout cycle itself refuses bytes (rx_ready is low here)
        if (idle_cnt_r == TO_VAL) begin
          timeout_s  = 1'b1;
          state_n    = IDLE;
          byte_cnt_n = 2'd0;
        end else if (rx_fire_s) begin
          if (state_r == ADDR && byte_cnt_r == 2'd2) begin
            state_n    = op_wr_r ? WDATA : BUS;
            byte_cnt_n = 2'd0;
          end else if (state_r == WDATA && byte_cnt_r == 2'd3) begin
            state_n    = BUS;
            byte_cnt_n = 2'd0;
          end else begin
            byte_cnt_n = byte_cnt_r + 2'd1;
          end
        end else begin
          idle_cnt_n = idle_cnt_r + IW'(1);
        end
      end
      BUS: begin
        state_n = RESP;
      end
      RESP: begin
        if (tx_fire_s && resp_left_r == 3'd1) begin
          state_n = IDLE;
        end else begin
          state_n = RESP;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, counters and registered handshake/strobe outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      byte_cnt_r <= 2'd0;
      idle_cnt_r <= '0;
      rx_ready_r <= 1'b1;
      tx_valid_r <= 1'b0;
      busy_r     <= 1'b0;
      cs_r       <= 1'b0;
      wr_r       <= 1'b0;
      rd_r       <= 1'b0;
    end else begin
      state_r    <= state_n;
      byte_cnt_r <= byte_cnt_n;
      idle_cnt_r <= idle_cnt_n;
      rx_ready_r <= (state_n == IDLE) ||
                    ((state_n == ADDR || state_n == WDATA) && idle_cnt_n != TO_VAL);
      tx_valid_r <= (state_n == RESP);
      busy_r     <= (state_n != IDLE);
      cs_r       <= (state_n == BUS);
      wr_r       <= (state_n == BUS) && op_wr_r;
      rd_r       <= (state_n == BUS) && !op_wr_r;
    end
  end

  // Frame assembly, response shifter and error counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_wr_r     <= 1'b0;
      addr_r      <= 21'h0;
      wdata_r     <= 32'h0;
      resp_sr_r   <= 32'h0;
      resp_left_r <= 3'd0;
      err_cnt_r   <= 8'h0;
    end else begin
      if (state_r == IDLE && rx_fire_s) begin
        op_wr_r <= (rx_data == OP_WR);
      end
      // Three shifts of 8 into 21 bits drop the first byte's top three bits
      if (state_r == ADDR && rx_fire_s) begin
        addr_r <= {addr_r[12:0], rx_data};
      end
      if (state_r == WDATA && rx_fire_s) begin
        wdata_r <= {wdata_r[23:0], rx_data};
      end
      if (bad_op_s) begin
        resp_sr_r   <= {RSP_ERR, 24'h0};
        resp_left_r <= 3'd1;
      end else if (state_r == BUS) begin
        resp_sr_r   <= op_wr_r ? {RSP_ACK, 24'h0} : mmio_rd_data;
        resp_left_r <= op_wr_r ? 3'd1 : 3'd4;
      end else if (tx_fire_s) begin
        resp_sr_r   <= {resp_sr_r[23:0], 8'h00};
        resp_left_r <= resp_left_r - 3'd1;
      end
      if (bad_op_s || timeout_s) begin
        err_cnt_r <= sat_inc8(err_cnt_r);
      end
    end
  end

  assign rx_ready     = rx_ready_r;
  assign tx_valid     = tx_valid_r;
  assign tx_data      = resp_sr_r[31:24];
  assign mmio_cs      = cs_r;
  assign mmio_wr      = wr_r;
  assign mmio_rd      = rd_r;
  assign mmio_addr    = addr_r;
  assign mmio_wr_data = wdata_r;
  assign busy         = busy_r;
  assign err_cnt      = err_cnt_r;

endmodule

// File: tb/tb_fpro_dbg_master.sv
// Self-checking bench for fpro_dbg_master: frame-level model with queues of
// expected bus accesses and response bytes, checked every cycle by one monitor.
module tb_fpro_dbg_master;

  localparam int TO = 16;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        mmio_cs, mmio_wr, mmio_rd;
  logic [20:0] mmio_addr;
  logic [31:0] mmio_wr_data;
  logic [31:0] mmio_rd_data;
  logic        busy;
  logic [7:0]  err_cnt;

  fpro_dbg_master #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .mmio_cs(mmio_cs), .mmio_wr(mmio_wr), .mmio_rd(mmio_rd),
    .mmio_addr(mmio_addr), .mmio_wr_data(mmio_wr_data), .mmio_rd_data(mmio_rd_data),
    .busy(busy), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave read data depends only on the address
  function automatic logic [31:0] rd_val(input logic [20:0] a);
    if (a == 21'h000104) return 32'h12345678;
    return {11'h5A5, a} ^ 32'h0F0F_0F0F;
  endfunction
  assign mmio_rd_data = rd_val(mmio_addr);

  typedef struct packed {
    logic [20:0] addr;
    logic [31:0] wd;
    logic        wr;
  } bus_t;

  int          checks = 0;
  int          failures = 0;
  bus_t        exp_bus[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  exp_err;
  logic [7:0]  frame[$];
  logic        in_frame;
  logic [7:0]  op;
  int          cs_count = 0;
  bus_t        last_bus;
  logic [7:0]  tx_log[$];
  logic        tx_rand;
  logic        prev_hold, prev_cs;
  logic [7:0]  prev_data;
  bus_t        mon_t;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_bus.delete();
    exp_tx.delete();
    frame.delete();
    in_frame = 1'b0;
    exp_err  = 8'h00;
  endtask

  // Frame-level model: what one accepted byte implies for bus, response and errors
  task automatic model_accept(input logic [7:0] b);
    bus_t        t;
    logic [23:0] a24;
    logic [31:0] r;
    if (!in_frame) begin
      if (b == 8'h57 || b == 8'h52) begin
        in_frame = 1'b1;
        op = b;
        frame.delete();
      end else begin
        exp_tx.push_back(8'h3F);
        if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
      end
    end else begin
      frame.push_back(b);
      if (frame.size() == ((op == 8'h57) ? 7 : 3)) begin
        a24    = {frame[0], frame[1], frame[2]};
        t.addr = a24[20:0];
        t.wr   = (op == 8'h57);
        t.wd   = t.wr ? {frame[3], frame[4], frame[5], frame[6]} : 32'h0;
        exp_bus.push_back(t);
        if (t.wr) begin
          exp_tx.push_back(8'h4B);
        end else begin
          r = rd_val(t.addr);
          for (int i = 3; i >= 0; i--) exp_tx.push_back(r[i*8 +: 8]);
        end
        in_frame = 1'b0;
      end
    end
  endtask

  task automatic model_timeout();
    in_frame = 1'b0;
    frame.delete();
    if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance
  task automatic send_byte(input logic [7:0] b);
    int g;
    g = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("rx_accept_wait", rx_ready, 1'b1);
    @(negedge clk);
    rx_valid = 1'b0;
    model_accept(b);
  endtask

  task automatic send_w(input logic [20:0] a, input logic [2:0] top, input logic [31:0] d);
    send_byte(8'h57);
    send_byte({top, a[20:16]});
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    for (int i = 3; i >= 0; i--) send_byte(d[i*8 +: 8]);
  endtask

  task automatic send_r(input logic [20:0] a, input logic [2:0] top);
    send_byte(8'h52);
    send_byte({top, a[20:16]});
    send_byte(a[15:8]);
    send_byte(a[7:0]);
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((exp_tx.size() != 0 || busy) && g < 400) begin
      @(negedge clk);
      g++;
    end
    check("idle_reached", (exp_tx.size() == 0) && !busy, 1'b1);
  endtask

  // Response consumer: always ready, or a coin flip each cycle
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(negedge clk);
      tx_ready = tx_rand ? 1'($urandom_range(1, 0)) : 1'b1;
    end
  end

  // Per-cycle compare of DUT against the model queues
  initial begin
    prev_hold = 1'b0;
    prev_cs   = 1'b0;
    prev_data = 8'h00;
    forever begin
      @(negedge clk);
      #2;
      if (!reset) begin
        check("reset_outputs",
              {rx_ready, tx_valid, tx_data, mmio_cs, mmio_wr, mmio_rd,
               mmio_addr, mmio_wr_data, busy, err_cnt},
              {1'b1, 74'h0});
        prev_hold = 1'b0;
        prev_cs   = 1'b0;
      end else begin
        check("err_cnt", err_cnt, exp_err);
        check("strobe_without_cs", (mmio_wr | mmio_rd) & ~mmio_cs, 1'b0);
        check("rx_tx_exclusive", rx_ready & tx_valid, 1'b0);
        if (mmio_cs) begin
          check("cs_one_cycle", prev_cs, 1'b0);
          check("rx_ready_in_bus", rx_ready, 1'b0);
          check("strobe_expected", exp_bus.size() > 0, 1'b1);
          if (exp_bus.size() > 0) begin
            mon_t = exp_bus.pop_front();
            check("bus_addr", mmio_addr, mon_t.addr);
            check("bus_wr", mmio_wr, mon_t.wr);
            check("bus_rd", mmio_rd, !mon_t.wr);
            if (mon_t.wr) check("bus_wdata", mmio_wr_data, mon_t.wd);
          end
          cs_count++;
          last_bus.addr = mmio_addr;
          last_bus.wd   = mmio_wr_data;
          last_bus.wr   = mmio_wr;
        end
        if (tx_valid || mmio_cs) check("busy", busy, 1'b1);
        if (prev_hold) begin
          check("tx_hold_valid", tx_valid, 1'b1);
          check("tx_hold_data", tx_data, prev_data);
        end
        if (tx_valid && tx_ready) begin
          check("tx_expected", exp_tx.size() > 0, 1'b1);
          if (exp_tx.size() > 0) check("tx_byte", tx_data, exp_tx.pop_front());
          tx_log.push_back(tx_data);
        end
        prev_hold = tx_valid && !tx_ready;
        prev_data = tx_data;
        prev_cs   = mmio_cs;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  int c0, n0;

  initial begin
    reset    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_rand  = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_rx_ready", rx_ready, 1'b1);
    check("reset_err_cnt", err_cnt, 8'd0);
    reset = 1'b1;
    @(negedge clk);

    // Write frame with latency check
    c0 = cs_count;
    send_w(21'h000010, 3'b000, 32'hDEADBEEF);
    check("w_strobe_n1", {mmio_cs, mmio_wr, mmio_rd}, 3'b110);
    @(negedge clk);
    check("w_tx_n2", {tx_valid, tx_data}, {1'b1, 8'h4B});
    wait_idle();
    check("w_addr_lit", last_bus.addr, 21'h000010);
    check("w_data_lit", last_bus.wd, 32'hDEADBEEF);
    check("w_one_strobe", cs_count - c0, 1);

    // Read frame, discarded top address bits
    send_r(21'h000104, 3'b111);
    check("r_strobe_n1", {mmio_cs, mmio_wr, mmio_rd}, 3'b101);
    @(negedge clk);
    check("r_tx_n2", {tx_valid, tx_data}, {1'b1, 8'h12});
    wait_idle();
    check("r_addr_lit", last_bus.addr, 21'h000104);
    n0 = tx_log.size();
    check("r_bytes_lit", {tx_log[n0-4], tx_log[n0-3], tx_log[n0-2], tx_log[n0-1]}, 32'h12345678);

    // Inter-byte timeout; a byte offered in the timeout cycle is ignored
    c0 = cs_count;
    n0 = tx_log.size();
    send_byte(8'h57);
    send_byte(8'h00);
    repeat (15) @(negedge clk);
    check("to_ready_before", {rx_ready, busy}, 2'b11);
    @(negedge clk);
    check("to_ready_timeout_cycle", rx_ready, 1'b0);
    rx_data  = 8'h52;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    model_timeout();
    check("to_idle", busy, 1'b0);
    check("to_err_lit", err_cnt, 8'd1);
    check("to_no_strobe", cs_count - c0, 0);
    check("to_no_tx", tx_log.size() - n0, 0);
    send_r(21'h01ABCD, 3'b010);
    wait_idle();
    check("to_next_frame", last_bus.addr, 21'h01ABCD);

    // Reads and a write with a stalling consumer
    tx_rand = 1'b1;
    send_r(21'h000ABC, 3'b000);
    send_r(21'h1FFFFF, 3'b101);
    send_w(21'h00F00D, 3'b000, 32'hA5C3_0F96);
    wait_idle();
    tx_rand = 1'b0;

    // Reset while the third data byte is offered
    send_byte(8'h57);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h10);
    send_byte(8'hDE);
    send_byte(8'hAD);
    c0 = cs_count;
    n0 = tx_log.size();
    rx_data  = 8'hBE;
    rx_valid = 1'b1;
    reset    = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rx_valid = 1'b0;
    reset    = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_no_strobe", cs_count - c0, 0);
    check("rst_no_tx", tx_log.size() - n0, 0);
    check("rst_idle", {busy, rx_ready, err_cnt}, {1'b0, 1'b1, 8'd0});
    send_w(21'h0ABCDE, 3'b000, 32'h0102_0304);
    wait_idle();
    check("rst_next_addr", last_bus.addr, 21'h0ABCDE);
    check("rst_next_data", last_bus.wd, 32'h0102_0304);

    // Bad opcodes and error saturation
    send_byte(8'h41);
    wait_idle();
    check("bad_err_lit", err_cnt, 8'd1);
    check("bad_tx_lit", tx_log[tx_log.size()-1], 8'h3F);
    repeat (300) send_byte(8'h41);
    wait_idle();
    check("err_saturate_lit", err_cnt, 8'd255);

    check("bus_queue_empty", exp_bus.size(), 0);
    check("tx_queue_empty", exp_tx.size(), 0);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
